// File: rtl/cpu_run_ctrl.sv
// CPU run/halt/single-step sequencer: debounces btn1 (reset) and btn2
// (halt/step, long press = run), drives CPU reset, clock enable and cycle count.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   btn1, btn2     : raw active-low buttons (asynchronous)
//   mem_ready      : memory ready; a step is held while this is low
//   cpu_reset_n    : CPU reset, active-low, registered
//   cpu_clk_en     : CPU clock enable, registered
//   step_mode      : 1 = halt/step mode selected
//   halted         : 1 while halted
//   step_count     : enabled CPU cycles since the last CPU reset
module cpu_run_ctrl #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'hFFFFFF,
  parameter logic [23:0] LONG_CYCLES     = 24'hFFFFFF,
  parameter int unsigned RESET_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn1,
  input  logic        btn2,
  input  logic        mem_ready,
  output logic        cpu_reset_n,
  output logic        cpu_clk_en,
  output logic        step_mode,
  output logic        halted,
  output logic [15:0] step_count
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RMAX = RW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RST,
    S_RUN,
    S_HALT,
    S_STEP
  } state_e;

  // index 0 = btn1, index 1 = btn2
  logic [1:0]  raw;
  logic [1:0]  s1_q;
  logic [1:0]  s2_q;
  logic [1:0]  deb_q;
  logic [1:0]  prs_q;
  logic [23:0] cnt_q [2];

  logic [23:0] lcnt_q;
  logic        long_q;

  state_e      state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic        mode_q, mode_d;
  logic        rstn_q, rstn_d;
  logic        en_q, en_d;
  logic        halt_q, halt_d;
  logic [15:0] cnt16_q;

  assign raw = {btn2, btn1};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 2'b11;
      s2_q  <= 2'b11;
      deb_q <= 2'b11;
      prs_q <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        prs_q[i] <= 1'b0;
        if (s2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DEBOUNCE_CYCLES - 24'd1) begin
            deb_q[i] <= s2_q[i];
            cnt_q[i] <= '0;
            prs_q[i] <= ~s2_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 24'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // lcnt parks at LONG_CYCLES after firing so the pulse is once per press
  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (deb_q[1]) begin
        lcnt_q <= '0;
      end else if (lcnt_q == LONG_CYCLES - 24'd1) begin
        lcnt_q <= LONG_CYCLES;
        long_q <= 1'b1;
      end else if (lcnt_q != LONG_CYCLES) begin
        lcnt_q <= lcnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      rcnt_q  <= '0;
      mode_q  <= 1'b0;
      rstn_q  <= 1'b0;
      en_q    <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      mode_q  <= mode_d;
      rstn_q  <= rstn_d;
      en_q    <= en_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    mode_d  = mode_q;
    if (prs_q[0]) begin
      state_d = S_RST;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_RST: begin
          if (rcnt_q == RMAX) begin
            state_d = mode_q ? S_HALT : S_RUN;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (prs_q[1]) begin
            state_d = S_HALT;
            mode_d  = 1'b1;
          end
        end
        S_HALT: begin
          if (long_q) begin
            state_d = S_RUN;
            mode_d  = 1'b0;
          end else if (prs_q[1]) begin
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          if (mem_ready) state_d = S_HALT;
        end
        default: state_d = S_RST;
      endcase
    end
    // outputs follow the next state so they switch on the state edge
    rstn_d = (state_d != S_RST);
    en_d   = (state_d == S_RUN) || (state_d == S_STEP);
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt16_q <= '0;
    end else if (!rstn_q) begin
      cnt16_q <= '0;
    end else if (en_q) begin
      cnt16_q <= cnt16_q + 16'd1;
    end
  end

  assign cpu_reset_n = rstn_q;
  assign cpu_clk_en  = en_q;
  assign step_mode   = mode_q;
  assign halted      = halt_q;
  assign step_count  = cnt16_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl.
// Debounce 4, long press 8, reset length 3.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        btn1;
  logic        btn2;
  logic        mem_ready;
  logic        cpu_reset_n;
  logic        cpu_clk_en;
  logic        step_mode;
  logic        halted;
  logic [15:0] step_count;

  int n_chk;
  int n_pass;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(24'd4),
    .LONG_CYCLES    (24'd8),
    .RESET_CYCLES   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn1       (btn1),
    .btn2       (btn2),
    .mem_ready  (mem_ready),
    .cpu_reset_n(cpu_reset_n),
    .cpu_clk_en (cpu_clk_en),
    .step_mode  (step_mode),
    .halted     (halted),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance n rising edges, then settle past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag,
                    input logic rn, input logic en,
                    input logic hl, input logic sm);
    chk({tag, ".rstn"}, 32'(cpu_reset_n), 32'(rn));
    chk({tag, ".en"},   32'(cpu_clk_en),  32'(en));
    chk({tag, ".halt"}, 32'(halted),      32'(hl));
    chk({tag, ".mode"}, 32'(step_mode),   32'(sm));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    btn1 = 1'b1;
    btn2 = 1'b1;
    mem_ready = 1'b1;
    cyc(1);
    st("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.cnt", 32'(step_count), 32'd0);

    // power-up: reset_n low 3 cycles then RUN
    reset = 1'b0;
    cyc(2);
    st("pu2", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    st("pu3", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pu3.cnt", 32'(step_count), 32'd0);
    cyc(1);
    chk("pu.c1", 32'(step_count), 32'd1);
    cyc(2);
    chk("pu.c3", 32'(step_count), 32'd3);

    // 3-cycle glitch is rejected
    btn2 = 1'b0;
    cyc(3);
    btn2 = 1'b1;
    cyc(10);
    st("glitch", 1'b1, 1'b1, 1'b0, 1'b0);

    // 20-cycle hold: HALT at edge 7, long pulse resumes RUN at edge 15
    btn2 = 1'b0;
    cyc(6);
    st("h20.e6", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    st("h20.e7", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(7);
    st("h20.e14", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1);
    st("h20.e15", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5);
    btn2 = 1'b1;
    cyc(10);
    st("h20.rel", 1'b1, 1'b1, 1'b0, 1'b0);

    // short press: RUN -> HALT
    btn2 = 1'b0;
    cyc(5);
    btn2 = 1'b1;
    cyc(2);
    st("halt", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(6);

    // btn1 in HALT: reset sequence, back to HALT
    btn1 = 1'b0;
    cyc(5);
    btn1 = 1'b1;
    cyc(1);
    st("r1.e6", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1);
    st("r1.e7", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(2);
    st("r1.e9", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("r1.cnt0", 32'(step_count), 32'd0);
    cyc(1);
    st("r1.e10", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("r1.cnt", 32'(step_count), 32'd0);
    cyc(6);

    // single step, mem_ready=1
    btn2 = 1'b0;
    cyc(5);
    btn2 = 1'b1;
    cyc(1);
    chk("s1.e6", 32'(cpu_clk_en), 32'd0);
    cyc(1);
    st("s1.e7", 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1);
    st("s1.e8", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("s1.cnt", 32'(step_count), 32'd1);
    cyc(6);

    // single step stretched by 2 mem_ready-low cycles
    mem_ready = 1'b0;
    btn2 = 1'b0;
    cyc(5);
    btn2 = 1'b1;
    cyc(2);
    chk("s2.e7", 32'(cpu_clk_en), 32'd1);
    cyc(2);
    chk("s2.e9", 32'(cpu_clk_en), 32'd1);
    mem_ready = 1'b1;
    cyc(1);
    st("s2.e10", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("s2.cnt", 32'(step_count), 32'd4);
    cyc(6);

    // long press in HALT: one step, then RUN
    btn2 = 1'b0;
    cyc(7);
    st("lp.e7", 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1);
    st("lp.e8", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("lp.cnt8", 32'(step_count), 32'd5);
    cyc(7);
    st("lp.e15", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(15);
    st("lp.e30", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lp.cnt30", 32'(step_count), 32'd20);
    btn2 = 1'b1;
    cyc(8);
    st("lp.rel", 1'b1, 1'b1, 1'b0, 1'b0);

    // btn1 in RUN: back to RUN
    btn1 = 1'b0;
    cyc(5);
    btn1 = 1'b1;
    cyc(2);
    st("r2.e7", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3);
    st("r2.e10", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("r2.cnt", 32'(step_count), 32'd0);
    cyc(6);

    // simultaneous presses: btn1 wins, btn2 dropped
    btn1 = 1'b0;
    btn2 = 1'b0;
    cyc(5);
    btn1 = 1'b1;
    btn2 = 1'b1;
    cyc(2);
    st("sim.e7", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3);
    st("sim.e10", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim.cnt", 32'(step_count), 32'd0);

    // count wrap
    cyc(65535);
    chk("wrap.ffff", 32'(step_count), 32'h0000FFFF);
    cyc(1);
    chk("wrap.0", 32'(step_count), 32'd0);
    st("wrap.st", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

CPU run/step/reset sequencer for the SoC top level. It debounces the two board buttons and drives the CPU reset and a CPU clock-enable, replacing the ad-hoc button state machine and gated CPU clock. It supports free-run, halt and single-step modes, and keeps a 16-bit count of enabled CPU cycles for the SSD display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 24'hFFFFFF: consecutive stable synchronized cycles before a button level is accepted (≥2).
- LONG_CYCLES, 24'hFFFFFF: cycles the debounced btn2 must stay pressed to count as a long press (≥2).
- RESET_CYCLES, 16: cycles cpu_reset_n is held low per reset sequence (≥1).

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- btn1, in, 1: raw button, active-low, asynchronous.
- btn2, in, 1: raw button, active-low, asynchronous.
- mem_ready, in, 1: memory ready from `memory`; used to stretch a single step.
- cpu_reset_n, out, 1: CPU reset, active-low, registered.
- cpu_clk_en, out, 1: CPU clock enable, registered.
- step_mode, out, 1: 1 = halt/step mode selected.
- halted, out, 1: 1 while in HALT.
- step_count, out, 16: number of cycles with cpu_clk_en=1 and cpu_reset_n=1 since the last CPU reset.

## Operation
- Synchronizer: two flops per button, reset to 1.
- Debounce, per button: deb level resets to 1 and cnt resets to 0.
  - If sync2 != deb: cnt++.
  - When cnt==DEBOUNCE_CYCLES-1: deb<=sync2, cnt<=0. The registered 1-cycle press pulse is set if the new level is 0.
  - If sync2 == deb: cnt<=0. A glitch shorter than DEBOUNCE_CYCLES is therefore ignored.
- Long press (btn2): lcnt counts while deb2==0 and clears when deb2==1. When it reaches LONG_CYCLES-1 it emits a 1-cycle long pulse once per press; it saturates until release.
- FSM states: RESETTING, RUN, HALT, STEP. The reset value is RESETTING with rcnt=0.
  - RESETTING: cpu_reset_n=0, cpu_clk_en=0. rcnt counts to RESET_CYCLES-1, then goes to RUN if step_mode=0, else HALT.
  - RUN: cpu_reset_n=1, cpu_clk_en=1.
    - btn2 press → HALT and step_mode<=1.
  - HALT: cpu_clk_en=0, halted=1.
    - btn2 press → STEP.
    - btn2 long → RUN and step_mode<=0.
  - STEP: cpu_clk_en=1. Leave to HALT on the first cycle with mem_ready=1; stay (enable held) while mem_ready=0.
  - btn1 press in any state → RESETTING with rcnt<=0. step_mode is preserved. A press during RESETTING restarts the count.
- Priority in the same cycle: btn1 press > btn2 long > btn2 press.
  - A long press in HALT first issues one step (the press pulse arrives earlier), then resumes RUN.
- step_count:
  - Cleared while cpu_reset_n=0.
  - Otherwise +1 on each cycle with cpu_clk_en=1.
  - Wraps 16'hFFFF→0.
- Reset values: cpu_reset_n=0, cpu_clk_en=0, step_mode=0, halted=0, step_count=0. All debounce and long-press state is cleared.
  - Asserting reset mid-step or mid-debounce aborts the step and discards the partial debounce.

## Timing
- Outputs are registered from FSM state. cpu_reset_n, cpu_clk_en and halted change on the same edge as the state.
- Press latency: count the first edge that samples raw low as edge 1. The press pulse is high after edge DEBOUNCE_CYCLES+2, and the FSM outputs change at edge DEBOUNCE_CYCLES+3.
- Long latency: the long pulse is high LONG_CYCLES edges after the deb2 falling edge. The FSM acts on the following edge.
- Reset sequence:
  - After reset deasserts, cpu_reset_n is low for exactly RESET_CYCLES cycles.
  - On the cycle it rises, cpu_clk_en=1 (RUN) or 0 (HALT).
- Single step:
  - With mem_ready=1, cpu_clk_en is high for exactly 1 cycle.
  - With mem_ready low for N cycles of the step, it is high for N+1 cycles.

## Test plan
- Use DEBOUNCE_CYCLES=4, LONG_CYCLES=8, RESET_CYCLES=3 for all scenarios.
- Power-up: pulse reset for 1 cycle, buttons released → cpu_reset_n low for 3 cycles, then cpu_reset_n=1 and cpu_clk_en=1 on the same edge; step_count increments 1,2,3…
- Glitch reject: btn2 low for 3 cycles in RUN → no state change; low for 20 cycles → cpu_clk_en falls at edge 7 and halted=1.
- Single step: in HALT, tap btn2 with mem_ready=1 → cpu_clk_en high for 1 cycle and step_count +1. Repeat with mem_ready=0 for 2 cycles → enable high for 3 cycles and step_count +3.
- Long press: in HALT, hold btn2 for 30 cycles → one 1-cycle step, then RUN with step_mode=0 and cpu_clk_en=1 continuously.
- Reset preserves mode: in HALT, press btn1 → cpu_reset_n low for 3 cycles, step_count=0, then HALT with cpu_clk_en=0. The same in RUN returns to RUN.
- Simultaneous press and wrap: btn1 and btn2 pressed on the same edge → RESETTING, btn2 ignored. Preload step_count=16'hFFFF in RUN → next cycle 16'h0000.
